// File: rtl/video_text.sv
// video_text: 80x30 character text generator, 8x16 glyph cells on a 640x480 raster.
// Holds a 2400-byte text RAM (read-first, not reset) and a 256x16x8 font ROM.
// Optional feature: define VIDEO_TEXT_CURSOR_EN for a blinking underline cursor
// at cur_addr (scanlines 14-15, toggles every 16 frames).
module video_text #(
  parameter logic [5:0] FG_RGB = 6'b111111,
  parameter logic [5:0] BG_RGB = 6'b000001
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        pix_stb,
  input  logic        i_hpix,
  input  logic        i_vpix,
  input  logic        v_init,
  input  logic        h_init,
  input  logic        h_step,
  input  logic        h_char,
  input  logic        wr_stb,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [11:0] cur_addr,
  output logic [1:0]  red,
  output logic [1:0]  grn,
  output logic [1:0]  blu
);

  localparam logic [11:0] CELL_LIMIT    = 12'd2400;
  localparam logic [11:0] ROW_STRIDE    = 12'd80;
  localparam logic [11:0] LAST_ROW_BASE = 12'd2320;
  localparam logic [6:0]  ROW_COLS      = 7'd80;

  // Font ROM contents: blank for NUL and space, a real 'A', and a
  // code-derived pattern (code XOR {row,row}) for every other glyph.
  function automatic logic [7:0] font_row(input logic [7:0] code, input logic [3:0] row);
    logic [7:0] bits;
    bits = code ^ {row, row};
    if (code == 8'h00 || code == 8'h20) begin
      bits = '0;
    end else if (code == 8'h41) begin
      case (row)
        4'd2:                      bits = 8'h10;
        4'd3:                      bits = 8'h38;
        4'd4:                      bits = 8'h6C;
        4'd5, 4'd6:                bits = 8'hC6;
        4'd7:                      bits = 8'hFE;
        4'd8, 4'd9, 4'd10, 4'd11:  bits = 8'hC6;
        default:                   bits = '0;
      endcase
    end
    return bits;
  endfunction

  logic [7:0]  text_mem [0:2399];
  logic [7:0]  code_q;

  logic        run_q, run_d;
  logic        first_q, first_d;
  logic        past_q, past_d;
  logic [11:0] row_base_q, row_base_d;
  logic [3:0]  scanline_q, scanline_d;
  logic [11:0] col_addr_q, col_addr_d;
  logic [6:0]  col_cnt_q, col_cnt_d;
  logic        step1_q, step1_d;
  logic        fetch_ok_q, fetch_ok_d;
  logic [7:0]  font_q, font_d;
  logic [7:0]  shift_q, shift_d;
  logic [5:0]  rgb_q, rgb_d;
  logic        fetch_en;
  logic        col_ok;
  logic [7:0]  cursor_mask;

`ifdef VIDEO_TEXT_CURSOR_EN
  logic [4:0]  blink_q, blink_d;
  logic [11:0] addr1_q, addr1_d;
`else
  logic        unused_cur;
  assign unused_cur = ^cur_addr;
`endif

  // Text RAM write port and read-first character fetch; contents survive reset.
  always_ff @(posedge fclk) begin
    if (wr_stb && (wr_addr < CELL_LIMIT)) text_mem[wr_addr] <= wr_data;
    if (fetch_en) code_q <= text_mem[col_addr_q];
  end

  // Raster counters, two-stage fetch pipeline, pixel shifter and output colour.
  always_comb begin
    run_d      = run_q;
    first_d    = first_q;
    past_d     = past_q;
    row_base_d = row_base_q;
    scanline_d = scanline_q;
    col_addr_d = col_addr_q;
    col_cnt_d  = col_cnt_q;
    step1_d    = 1'b0;
    fetch_ok_d = fetch_ok_q;
    font_d     = font_q;
    shift_d    = shift_q;
    rgb_d      = rgb_q;

    col_ok   = (col_cnt_q < ROW_COLS) && !past_q;
    fetch_en = pix_stb && h_step && col_ok;

`ifdef VIDEO_TEXT_CURSOR_EN
    blink_d     = blink_q;
    addr1_d     = addr1_q;
    cursor_mask = (blink_q[4] && (scanline_q[3:1] == 3'b111) && (addr1_q == cur_addr)) ? 8'hFF : 8'h00;
`else
    cursor_mask = '0;
`endif

    // Second fetch stage: font lookup one cycle after the code latch.
    if (step1_q) font_d = fetch_ok_q ? (font_row(code_q, scanline_q) | cursor_mask) : '0;

    if (pix_stb) begin
      step1_d = h_step;
      if (h_step) fetch_ok_d = col_ok;
`ifdef VIDEO_TEXT_CURSOR_EN
      if (h_step) addr1_d = col_addr_q;
      if (v_init) blink_d = blink_q + 5'd1;
`endif
      if (v_init) begin
        run_d      = 1'b1;
        first_d    = 1'b1;
        past_d     = 1'b0;
        row_base_d = '0;
        scanline_d = '0;
        col_addr_d = '0;
        col_cnt_d  = '0;
      end else if (h_init) begin
        first_d   = 1'b0;
        col_cnt_d = '0;
        if (!first_q) begin
          scanline_d = scanline_q + 4'd1;
          if (scanline_q == 4'd15) begin
            // Past the last text row the base freezes and lines go blank.
            if (row_base_q == LAST_ROW_BASE) past_d = 1'b1;
            else row_base_d = row_base_q + ROW_STRIDE;
          end
        end
        col_addr_d = row_base_d;
      end else if (h_step) begin
        col_addr_d = col_addr_q + 12'd1;
        if (col_cnt_q < ROW_COLS) col_cnt_d = col_cnt_q + 7'd1;
      end

      // The pixel shown is the shifter MSB before this strobe's load/shift.
      rgb_d   = (run_q && i_hpix && i_vpix) ? (shift_q[7] ? FG_RGB : BG_RGB) : '0;
      shift_d = h_char ? font_q : {shift_q[6:0], 1'b0};
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      first_q    <= 1'b1;
      past_q     <= 1'b0;
      row_base_q <= '0;
      scanline_q <= '0;
      col_addr_q <= '0;
      col_cnt_q  <= '0;
      step1_q    <= 1'b0;
      fetch_ok_q <= 1'b0;
      font_q     <= '0;
      shift_q    <= '0;
      rgb_q      <= '0;
    end else begin
      run_q      <= run_d;
      first_q    <= first_d;
      past_q     <= past_d;
      row_base_q <= row_base_d;
      scanline_q <= scanline_d;
      col_addr_q <= col_addr_d;
      col_cnt_q  <= col_cnt_d;
      step1_q    <= step1_d;
      fetch_ok_q <= fetch_ok_d;
      font_q     <= font_d;
      shift_q    <= shift_d;
      rgb_q      <= rgb_d;
    end
  end

`ifdef VIDEO_TEXT_CURSOR_EN
  // Cursor blink counter and fetched-cell address tracking.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      addr1_q <= '0;
    end else begin
      blink_q <= blink_d;
      addr1_q <= addr1_d;
    end
  end
`endif

  assign red = rgb_q[5:4];
  assign grn = rgb_q[3:2];
  assign blu = rgb_q[1:0];

endmodule

// File: doc/video_text.md
VIDEO_TEXT -- requirements
Module: video_text

Interface
REQ-001 SHALL have parameter FG_RGB, default 6'b111111, foreground colour {red,grn,blu}.
REQ-002 SHALL have parameter BG_RGB, default 6'b000001, background colour {red,grn,blu}.
REQ-003 fclk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pix_stb  input  1  pixel strobe; one fclk cycle per pixel.
REQ-006 i_hpix, i_vpix  input  1 each  horizontal/vertical visible-area flags.
REQ-007 v_init  input  1  frame start, pix_stb-qualified, before the first visible line.
REQ-008 h_init  input  1  line start, pix_stb-qualified, before the first visible pixel.
REQ-009 h_step  input  1  fetch strobe, pix_stb-qualified, 8 pixels ahead of its h_char.
REQ-010 h_char  input  1  shifter-load strobe, pix_stb-qualified, every 8 pixels.
REQ-011 wr_stb  input  1  text-buffer write strobe, single cycle.
REQ-012 wr_addr  input  12  text-buffer cell address, row*80+col.
REQ-013 wr_data  input  8  character code.
REQ-014 cur_addr  input  12  cursor cell address.
REQ-015 red, grn, blu  output  2 each  pixel colour.

Function
REQ-016 SHALL hold an internal 80x30 (2400 x 8 bit) text RAM and a 256x16x8 font ROM; 8x16 cells give 640x480.
REQ-017 Write: wr_stb with wr_addr<2400 stores wr_data next edge; wr_addr>=2400 ignored; writes accepted any cycle, independent of pix_stb.
REQ-018 Same-cycle write and fetch to one address: fetch returns the old byte (read-first).
REQ-019 v_init: row_base<=0, scanline<=0, col_addr<=0.
REQ-020 h_init: col_addr<=row_base; no scanline advance on the first h_init after v_init; on later ones scanline increments 0..15; wrap 15->0 adds 80 to row_base.
REQ-021 row_base saturates at 2320; lines below row 29 render BG_RGB.
REQ-022 h_step: latch code at col_addr (1 cycle), font row {code,scanline} (1 cycle); col_addr+1; font byte valid within 2 fclk of h_step.
REQ-023 h_char: 8-bit shifter <= fetched byte, MSB first; each non-load pix_stb shifts left 1; h_step and h_char in one cycle are both honoured.
REQ-024 Output registered, 1 fclk after pix_stb: i_hpix&i_vpix -> FG_RGB if shifter MSB=1 else BG_RGB; otherwise 6'b000000.
REQ-025 h_step beyond column 79 of a row: fetch suppressed, shifter loads 0.
REQ-026 All outputs change only on pix_stb cycles, reset excepted.

Reset
REQ-027 rst_n low: red=grn=blu=0, shifter=0, row_base=0, scanline=0, col_addr=0, blink counter=0, within the same cycle.
REQ-028 Text RAM contents SHALL NOT be reset; reads after reset return prior or undefined data.
REQ-029 Reset mid-line: output 0 until next v_init; no write in progress is corrupted beyond the reset cycle.

Configuration
REQ-030 Macro VIDEO_TEXT_CURSOR_EN defined: 5-bit blink counter increments per v_init; when counter[4]=1, scanlines 14-15 of cell cur_addr render FG_RGB over all 8 pixels.
REQ-031 Macro undefined: no cursor logic or blink counter; cur_addr port present but ignored.

Verification
REQ-032 Write 0x41 at addr 0, drive one frame -> scanline 0..15 of cell (0,0) match font ROM 'A' rows, MSB first, 1 fclk after pix_stb.
REQ-033 Write at addr 2400 then 0 at 2399 -> cell (79,29) blank, no other cell changed.
REQ-034 Write addr 85 same cycle as its fetch (row 1, col 5) -> old code rendered this frame, new code next frame.
REQ-035 i_hpix=0 with shifter 0xFF -> red=grn=blu=0; i_vpix=1,i_hpix=1, bit 0 -> 2'b00,2'b00,2'b01.
REQ-036 rst_n low during line 100 -> outputs 0 same cycle; after v_init frame renders correctly.
REQ-037 VIDEO_TEXT_CURSOR_EN, cur_addr=0 -> frames 16-31 show FG on scanlines 14-15 of cell (0,0), frames 0-15 do not.
